// File: rtl/dvp_capture_gen2.sv
`default_nettype none
// =============================================================================
// Module   : dvp_capture_gen2
// Purpose  : DVP camera capture front end (pclk domain). It skips start-up
//            frames, assembles 1- or 2-beat pixels and outputs X/Y addresses.
//            Optional runtime crop window: define DVP_CROP_EN.
// Revision : 1.0 - initial release
// =============================================================================
module dvp_capture_gen2 #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 12,
  parameter int SKIP_FRAMES = 10,
  parameter int VSYNC_POL   = 1,
  parameter int HREF_POL    = 1
) (
  input  logic                  i_pclk,
  input  logic                  i_rst_n,
  input  logic                  i_vsync,
  input  logic                  i_href,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_mode,
`ifdef DVP_CROP_EN
  input  logic [ADDR_W-1:0]     i_crop_x0,
  input  logic [ADDR_W-1:0]     i_crop_x1,
  input  logic [ADDR_W-1:0]     i_crop_y0,
  input  logic [ADDR_W-1:0]     i_crop_y1,
`endif
  output logic [2*DATA_W-1:0]   o_pixel_out,
  output logic                  o_pixel_valid,
  output logic [ADDR_W-1:0]     o_xaddr,
  output logic [ADDR_W-1:0]     o_yaddr,
  output logic                  o_frame_start,
  output logic                  o_frame_done,
  output logic                  o_image_ready,
  output logic                  o_line_err
);

  localparam int SKIP_W = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic [SKIP_W-1:0] C_SKIP_LAST = SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
  localparam logic [ADDR_W-1:0] C_ADDR_MAX  = '1;
  localparam logic              C_VPOL      = (VSYNC_POL != 0);
  localparam logic              C_HPOL      = (HREF_POL != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SKIP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic                r_v, r_h, r_v_d, r_h_d;
  logic [DATA_W-1:0]   r_d, r_hi;
  logic [1:0]          r_state;
  logic [SKIP_W-1:0]   r_skip;
  logic                r_mode, r_beat_odd;
  logic [ADDR_W-1:0]   r_x, r_y;
  logic [2*DATA_W-1:0] r_pixel_out;
  logic                r_pixel_valid, r_frame_start, r_frame_done, r_line_err;
  logic [ADDR_W-1:0]   r_xaddr, r_yaddr;

  logic                w_v_rise, w_v_fall, w_h_fall, w_pix_done, w_in_win, w_emit;
  logic [2*DATA_W-1:0] w_pix;
  logic [ADDR_W-1:0]   w_xo, w_yo;

  assign w_v_rise   = r_v & ~r_v_d;
  assign w_v_fall   = ~r_v & r_v_d;
  assign w_h_fall   = ~r_h & r_h_d;
  assign w_pix_done = r_h & (r_mode | r_beat_odd);
  assign w_pix      = r_mode ? {{DATA_W{1'b0}}, r_d} : {r_hi, r_d};
  // r_v high covers the v-rise cycle, so a pixel colliding with frame start is dropped
  assign w_emit     = w_pix_done & (r_state == S_RUN) & ~r_v & w_in_win;

`ifdef DVP_CROP_EN
  logic [ADDR_W-1:0] r_cx0, r_cx1, r_cy0, r_cy1;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cx0 <= '0;
      r_cx1 <= '0;
      r_cy0 <= '0;
      r_cy1 <= '0;
    end else if (w_v_rise) begin
      r_cx0 <= i_crop_x0;
      r_cx1 <= i_crop_x1;
      r_cy0 <= i_crop_y0;
      r_cy1 <= i_crop_y1;
    end
  end

  assign w_in_win = (r_x >= r_cx0) && (r_x <= r_cx1) && (r_y >= r_cy0) && (r_y <= r_cy1);
  assign w_xo     = r_x - r_cx0;
  assign w_yo     = r_y - r_cy0;
`else
  assign w_in_win = 1'b1;
  assign w_xo     = r_x;
  assign w_yo     = r_y;
`endif

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v   <= 1'b0;
      r_h   <= 1'b0;
      r_v_d <= 1'b0;
      r_h_d <= 1'b0;
      r_d   <= '0;
    end else begin
      r_v   <= ~(i_vsync ^ C_VPOL);
      r_h   <= ~(i_href ^ C_HPOL);
      r_v_d <= r_v;
      r_h_d <= r_h;
      r_d   <= i_data;
    end
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_skip  <= '0;
      r_mode  <= 1'b0;
    end else begin
      if (w_v_rise) begin
        r_mode <= i_mode;
      end
      case (r_state)
        S_IDLE: begin
          r_skip <= '0;
          if (w_v_rise) begin
            r_state <= (SKIP_FRAMES == 0) ? S_RUN : S_SKIP;
          end
        end
        S_SKIP: begin
          if (w_v_rise) begin
            if (r_skip == C_SKIP_LAST) begin
              r_state <= S_RUN;
            end else begin
              r_skip <= r_skip + 1'b1;
            end
          end
        end
        S_RUN:   r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat_odd <= 1'b0;
      r_hi       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_line_err <= 1'b0;
    end else begin
      r_beat_odd <= r_h & ~r_beat_odd;
      if (r_h && !r_beat_odd) begin
        r_hi <= r_d;
      end
      if (!r_h) begin
        r_x <= '0;
      end else if (w_pix_done && r_x != C_ADDR_MAX) begin
        r_x <= r_x + 1'b1;
      end
      if (r_v) begin
        r_y <= '0;
      end else if (w_h_fall && r_y != C_ADDR_MAX) begin
        r_y <= r_y + 1'b1;
      end
      // r_beat_odd still holds the finished line's parity on the h falling-edge cycle
      if (w_v_rise) begin
        r_line_err <= 1'b0;
      end else if (w_h_fall && !r_mode && r_beat_odd) begin
        r_line_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pixel_valid <= 1'b0;
      r_pixel_out   <= '0;
      r_xaddr       <= '0;
      r_yaddr       <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_pixel_valid <= w_emit;
      if (w_emit) begin
        r_pixel_out <= w_pix;
        r_xaddr     <= w_xo;
        r_yaddr     <= w_yo;
      end
      r_frame_start <= w_v_rise;
      r_frame_done  <= w_v_fall & (r_state == S_RUN);
    end
  end

  assign o_pixel_out   = r_pixel_out;
  assign o_pixel_valid = r_pixel_valid;
  assign o_xaddr       = r_xaddr;
  assign o_yaddr       = r_yaddr;
  assign o_frame_start = r_frame_start;
  assign o_frame_done  = r_frame_done;
  assign o_image_ready = (r_state == S_RUN);
  assign o_line_err    = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_dvp_capture_gen2.sv
`default_nettype none
// tb_dvp_capture_gen2: random DVP frames driven into the capture block. The
// expected pixels are derived directly from each frame's byte stream.
module tb_dvp_capture_gen2;

  localparam int SKIP = 10;

  logic        clk = 1'b0;
  logic        rst_n, vsync, href, mode;
  logic [7:0]  data;
  logic [11:0] cx0 = 12'd0, cx1 = 12'hfff, cy0 = 12'd0, cy1 = 12'hfff;
  logic [15:0] o_pixel_out;
  logic        o_pixel_valid, o_frame_start, o_frame_done, o_image_ready, o_line_err;
  logic [11:0] o_xaddr, o_yaddr;

  always #5 clk = ~clk;

  dvp_capture_gen2 #(
    .DATA_W(8), .ADDR_W(12), .SKIP_FRAMES(SKIP), .VSYNC_POL(1), .HREF_POL(1)
  ) u_dut (
    .i_pclk        (clk),
    .i_rst_n       (rst_n),
    .i_vsync       (vsync),
    .i_href        (href),
    .i_data        (data),
    .i_mode        (mode),
`ifdef DVP_CROP_EN
    .i_crop_x0     (cx0),
    .i_crop_x1     (cx1),
    .i_crop_y0     (cy0),
    .i_crop_y1     (cy1),
`endif
    .o_pixel_out   (o_pixel_out),
    .o_pixel_valid (o_pixel_valid),
    .o_xaddr       (o_xaddr),
    .o_yaddr       (o_yaddr),
    .o_frame_start (o_frame_start),
    .o_frame_done  (o_frame_done),
    .o_image_ready (o_image_ready),
    .o_line_err    (o_line_err)
  );

  typedef struct { logic [15:0] p; int x; int y; int c; } exp_t;
  exp_t       exp_q[$];
  int         lb[$];
  logic [7:0] fixed_q[$];
  int cyc = 0, n_chk = 0, n_err = 0, n_fs = 0, n_fd = 0, frames = 0, abort_at = -1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_win(input int x, input int y);
    return (x >= int'(cx0)) && (x <= int'(cx1)) && (y >= int'(cy0)) && (y <= int'(cy1));
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (o_frame_start) n_fs++;
    if (o_frame_done)  n_fd++;
    if (o_pixel_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", o_pixel_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("pix_data", o_pixel_out, e.p);
        check_eq("pix_x", o_xaddr, e.x);
        check_eq("pix_y", o_yaddr, e.y);
        check_eq("pix_cycle", cyc, e.c);
      end
    end
  end

  task automatic do_reset();
    check_eq("ready_before_rst", o_image_ready, 1);
    check_eq("valid_before_rst", o_pixel_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_flags", {o_pixel_valid, o_frame_start, o_frame_done, o_image_ready, o_line_err}, 0);
    check_eq("arst_pix", o_pixel_out, 0);
    check_eq("arst_addr", {o_xaddr, o_yaddr}, 0);
    exp_q.delete();
    frames = 0;
    href = 1'b0;
    vsync = 1'b0;
    data = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_frame(input logic m);
    bit run, err;
    int x, y, fs0, fd0;
    logic [7:0] d, hi;
    frames++;
    run = (frames > SKIP);
    err = 0;
    fs0 = n_fs;
    fd0 = n_fd;
    hi  = 8'h00;
    mode = m;
    vsync = 1'b1;
    tick();
    repeat ($urandom_range(1, 3)) tick();
    check_eq("line_err_clr", o_line_err, 0);
    mode = 1'($urandom);
    vsync = 1'b0;
    repeat (3) tick();
    y = 0;
    foreach (lb[i]) begin
      x = 0;
      for (int b = 0; b < lb[i]; b++) begin
        if (i == 0 && b == abort_at) begin
          do_reset();
          return;
        end
        d = (fixed_q.size() != 0) ? fixed_q.pop_front() : 8'($urandom);
        href = 1'b1;
        data = d;
        if (m || (b % 2 == 1)) begin
          if (run && in_win(x, y))
            exp_q.push_back('{p: (m ? {8'h00, d} : {hi, d}), x: x - int'(cx0), y: y - int'(cy0), c: cyc + 2});
          x++;
        end else begin
          hi = d;
        end
        tick();
      end
      href = 1'b0;
      if (!m && (lb[i] % 2 == 1)) err = 1;
      repeat ($urandom_range(2, 4)) tick();
      y++;
    end
    repeat (2) tick();
    check_eq("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    check_eq("line_err", o_line_err, err);
    check_eq("image_ready", o_image_ready, run);
    check_eq("frame_start_cnt", n_fs - fs0, 1);
    check_eq("frame_done_cnt", n_fd - fd0, run);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish (errors=%0d of %0d checks)", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    vsync = 1'b0;
    href  = 1'b0;
    data  = 8'h00;
    mode  = 1'b0;
    repeat (3) tick();
    check_eq("rst_flags", {o_pixel_valid, o_frame_start, o_frame_done, o_image_ready, o_line_err}, 0);
    check_eq("rst_pix", o_pixel_out, 0);
    check_eq("rst_addr", {o_xaddr, o_yaddr}, 0);
    rst_n = 1'b1;
    tick();

    lb = '{8, 8};
    for (int f = 0; f < 12; f++) begin
      if (f == 11) fixed_q = '{8'hAB, 8'hCD};
      send_frame(1'b0);
    end
    lb = '{10};
    send_frame(1'b1);
    lb = '{5, 4};
    send_frame(1'b0);
    lb = '{4};
    send_frame(1'b0);
    repeat (6) begin
      lb.delete();
      repeat ($urandom_range(1, 3)) lb.push_back(int'($urandom_range(1, 12)));
      send_frame(1'($urandom));
    end

`ifdef DVP_CROP_EN
    lb = '{12, 12, 12};
    cx0 = 12'd2; cx1 = 12'd3; cy0 = 12'd1; cy1 = 12'd1;
    send_frame(1'b0);
    cx0 = 12'd3; cx1 = 12'd2;
    send_frame(1'b0);
    cx0 = 12'd0; cx1 = 12'hfff; cy0 = 12'd0; cy1 = 12'hfff;
`endif

    lb = '{8};
    abort_at = 3;
    send_frame(1'b1);
    abort_at = -1;
    lb = '{4};
    repeat (SKIP + 1) send_frame(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
